// File: rtl/kbd_event_queue.sv
// kbd_event_queue
//   Turns changes on the PS/2 assembler's key_code output into compact
//   make/break event words and queues them in a show-ahead FIFO that the CPU
//   drains one word per read.
//
//   Pipeline: capture (edge N) -> decode (edge N+1) -> FIFO write (edge N+2).
//
// Ports
//   clk       in   system clock, all state on posedge
//   clrn      in   asynchronous active-low reset
//   en        in   capture enable
//   key_code  in   32-bit assembler output (make/break/extended encodings)
//   rd_en     in   pop strobe, one pulse per CPU read
//   clr_ovf   in   clears the sticky overflow flag
//   rd_data   out  head event word, 0 when empty
//   empty     out  FIFO holds no events
//   count     out  number of stored events, 0..DEPTH
//   overflow  out  sticky, set when an event was dropped on a full FIFO
module kbd_event_queue #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     en,
  input  logic [31:0]              key_code,
  input  logic                     rd_en,
  input  logic                     clr_ovf,
  output logic [31:0]              rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // ---------------- stage 1: capture ----------------
  logic [31:0] prev_q;
  logic        cap_vld_q;
  logic [23:0] cap_code_q;
  logic        code_valid_s;
  logic        event_s;

  // Classify the incoming code and decide whether it is a new event.
  always_comb begin
    code_valid_s = (key_code[31:8] == 24'h000000) ||
                   (key_code[31:8] == 24'h0000E0) ||
                   (key_code[31:8] == 24'h0000F0) ||
                   (key_code[31:8] == 24'h00E0F0);
    event_s = en && (key_code != prev_q) && (key_code != 32'h0000_0000) &&
              code_valid_s && (key_code[7:0] != 8'h00);
  end

  // Capture register; prev tracks key_code every cycle regardless of en.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      prev_q     <= 32'h0000_0000;
      cap_vld_q  <= 1'b0;
      cap_code_q <= 24'h000000;
    end else begin
      prev_q     <= key_code;
      cap_vld_q  <= event_s;
      cap_code_q <= key_code[23:0];
    end
  end

  // ---------------- stage 2: decode ----------------
  logic        shift_l_q, shift_r_q, ctrl_q, alt_q;
  logic        shift_l_d, shift_r_d, ctrl_d, alt_d;
  logic        brk_s, ext_s;
  logic [7:0]  scan_s;
  logic        dec_vld_q;
  logic [15:0] dec_word_q, dec_word_d;

  // Decode the captured code and apply it to the modifier state; the word
  // reports modifiers as they stand after this event.
  always_comb begin
    brk_s  = (cap_code_q[15:8] == 8'hF0);
    ext_s  = (cap_code_q[15:8] == 8'hE0) || (cap_code_q[23:16] == 8'hE0);
    scan_s = cap_code_q[7:0];
    shift_l_d = shift_l_q;
    shift_r_d = shift_r_q;
    ctrl_d    = ctrl_q;
    alt_d     = alt_q;
    if (cap_vld_q) begin
      if ((scan_s == 8'h12) && !ext_s) begin
        shift_l_d = !brk_s;
      end else if ((scan_s == 8'h59) && !ext_s) begin
        shift_r_d = !brk_s;
      end else if (scan_s == 8'h14) begin
        ctrl_d = !brk_s;
      end else if (scan_s == 8'h11) begin
        alt_d = !brk_s;
      end else begin
        shift_l_d = shift_l_q;
      end
    end else begin
      shift_l_d = shift_l_q;
    end
    dec_word_d = {brk_s, ext_s, 3'b000, (shift_l_d | shift_r_d), ctrl_d, alt_d, scan_s};
  end

  // Decode register and modifier state.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      dec_vld_q  <= 1'b0;
      dec_word_q <= 16'h0000;
      shift_l_q  <= 1'b0;
      shift_r_q  <= 1'b0;
      ctrl_q     <= 1'b0;
      alt_q      <= 1'b0;
    end else begin
      dec_vld_q  <= cap_vld_q;
      dec_word_q <= dec_word_d;
      shift_l_q  <= shift_l_d;
      shift_r_q  <= shift_r_d;
      ctrl_q     <= ctrl_d;
      alt_q      <= alt_d;
    end
  end

  // ---------------- FIFO ----------------
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          pop_s, push_ok_s, drop_s;

  // FIFO control: a full FIFO still accepts a push when a pop frees a slot
  // in the same cycle; a pop on an empty FIFO is ignored.
  always_comb begin
    pop_s     = rd_en && (count_q != {CW{1'b0}});
    push_ok_s = dec_vld_q && ((count_q != CNT_FULL) || pop_s);
    drop_s    = dec_vld_q && !push_ok_s;
    rd_ptr_d  = pop_s     ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    wr_ptr_d  = push_ok_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    if (push_ok_s && !pop_s) begin
      count_d = count_q + CNT_ONE;
    end else if (!push_ok_s && pop_s) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rd_ptr_q   <= {AW{1'b0}};
      wr_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are masked by count so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= dec_word_q;
    end
  end

  // Outputs are straight decodes of registered state.
  always_comb begin
    empty    = (count_q == {CW{1'b0}});
    count    = count_q;
    overflow = overflow_q;
    if (count_q != {CW{1'b0}}) begin
      rd_data = {16'h0000, mem_q[rd_ptr_q]};
    end else begin
      rd_data = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_kbd_event_queue.sv
module tb_kbd_event_queue;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        clrn, en, rd_en, clr_ovf;
  logic [31:0] key_code;
  logic [31:0] rd_data;
  logic        empty, overflow;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  kbd_event_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .clrn(clrn), .en(en), .key_code(key_code), .rd_en(rd_en),
    .clr_ovf(clr_ovf), .rd_data(rd_data), .empty(empty), .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Expected FIFO contents as a plain queue; events travel through a
  // two-slot delay line before they reach the queue.
  logic [31:0] exp_q[$];
  logic [31:0] m_prev;
  bit          m_sl, m_sr, m_ctrl, m_alt, m_ovf;
  bit          p1_v, p2_v;
  logic [31:0] p1_w, p2_w;

  task automatic model_reset();
    exp_q.delete();
    m_prev = 32'h0; m_sl = 0; m_sr = 0; m_ctrl = 0; m_alt = 0; m_ovf = 0;
    p1_v = 0; p2_v = 0; p1_w = 32'h0; p2_w = 32'h0;
  endtask

  task automatic model_edge();
    int unsigned hi, scan;
    bit valid, brk, ext, evt, fire_pop, accept;
    logic [31:0] w;
    // queue update with the word that was detected two edges ago
    fire_pop = rd_en && (exp_q.size() > 0);
    accept   = p2_v && ((exp_q.size() < DEPTH) || fire_pop);
    if (fire_pop) void'(exp_q.pop_front());
    if (accept) exp_q.push_back(p2_w);
    if (p2_v && !accept) m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
    p2_v = p1_v; p2_w = p1_w;
    // event detection and decode
    hi    = key_code >> 8;
    scan  = key_code & 32'hFF;
    valid = (hi == 0) || (hi == 32'hE0) || (hi == 32'hF0) || (hi == 32'hE0F0);
    evt   = en && (key_code != m_prev) && (key_code != 0) && valid && (scan != 0);
    m_prev = key_code;
    p1_v = evt; p1_w = 32'h0;
    if (evt) begin
      brk = (hi == 32'hF0) || (hi == 32'hE0F0);
      ext = (hi == 32'hE0) || (hi == 32'hE0F0);
      if (scan == 32'h12 && !ext) m_sl = !brk;
      if (scan == 32'h59 && !ext) m_sr = !brk;
      if (scan == 32'h14) m_ctrl = !brk;
      if (scan == 32'h11) m_alt = !brk;
      w = scan;
      if (brk) w += 32'h8000;
      if (ext) w += 32'h4000;
      if (m_sl || m_sr) w += 32'h400;
      if (m_ctrl) w += 32'h200;
      if (m_alt) w += 32'h100;
      p1_w = w;
    end
  endtask

  always @(posedge clk or negedge clrn) begin
    if (!clrn) model_reset();
    else model_edge();
  end

  // ---------------- comparison helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs with the model away from the active edge.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("mon_count", 32'(count), 32'(exp_q.size()));
      chk("mon_empty", 32'(empty), (exp_q.size() == 0) ? 32'd1 : 32'd0);
      chk("mon_rd_data", rd_data, (exp_q.size() > 0) ? exp_q[0] : 32'h0);
      chk("mon_overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    key_code = 32'h0; en = 1'b1; rd_en = 1'b0; clr_ovf = 1'b0;
    clrn = 1'b0;
    step(); step();
    clrn = 1'b1;
    step();
  endtask

  task automatic expect_pop(input string name, input logic [31:0] exp);
    chk(name, rd_data, exp);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  function automatic logic [31:0] rand_code();
    logic [7:0] sc;
    case ($urandom_range(0, 6))
      0: sc = 8'h12;
      1: sc = 8'h59;
      2: sc = 8'h14;
      3: sc = 8'h11;
      4: sc = 8'h00;
      default: sc = 8'($urandom_range(0, 255));
    endcase
    case ($urandom_range(0, 9))
      0, 1: rand_code = 32'h0;
      2, 3, 4: rand_code = {24'h0, sc};
      5: rand_code = {16'h0, 8'hE0, sc};
      6, 7: rand_code = {16'h0, 8'hF0, sc};
      8: rand_code = {8'h0, 16'hE0F0, sc};
      default: rand_code = {16'h0, 8'hAB, sc};
    endcase
  endfunction

  initial begin
    clrn = 1'b0; en = 1'b1; rd_en = 1'b0; clr_ovf = 1'b0; key_code = 32'h0;
    model_reset();
    step();
    mon_on = 1'b1;
    do_reset();
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);

    // Single held code gives exactly one entry.
    key_code = 32'h0000_001C;
    step(); step(); step();
    chk("single_rd_data", rd_data, 32'h0000_001C);
    repeat (7) step();
    chk("single_count", 32'(count), 32'd1);

    // Shift make, plain key, shift break.
    do_reset();
    key_code = 32'h12;   step();
    key_code = 32'h0;    step();
    key_code = 32'h1C;   step();
    key_code = 32'h0;    step();
    key_code = 32'hF012; step();
    key_code = 32'h0;    step(); step(); step();
    chk("shift_count", 32'(count), 32'd3);
    expect_pop("shift_w0", 32'h0000_0412);
    expect_pop("shift_w1", 32'h0000_041C);
    expect_pop("shift_w2", 32'h0000_8012);

    // Extended make/break and an invalid code.
    do_reset();
    key_code = 32'h0000_E014; step();
    key_code = 32'h00E0_F014; step();
    key_code = 32'h0000_AB1C; step();
    key_code = 32'h0;         step(); step(); step();
    chk("ext_count", 32'(count), 32'd2);
    expect_pop("ext_make", 32'h0000_4214);
    expect_pop("ext_break", 32'h0000_C014);
    chk("ext_invalid_none", 32'(count), 32'd0);

    // Overflow: DEPTH+1 events with no reads.
    do_reset();
    for (int i = 1; i <= DEPTH + 1; i++) begin
      key_code = 32'(i); step();
    end
    key_code = 32'h0; step(); step(); step();
    chk("ovf_count", 32'(count), 32'(DEPTH));
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 1; i <= DEPTH; i++) expect_pop("ovf_readback", 32'(i));
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO with a push and a pop landing on the same edge.
    do_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      key_code = 32'(i); step();
    end
    key_code = 32'h20; step(); step();
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("full_pp_count", 32'(count), 32'(DEPTH));
    chk("full_pp_overflow", 32'(overflow), 32'd0);
    chk("full_pp_head", rd_data, 32'h2);

    // Pop on empty is ignored.
    do_reset();
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("empty_pop_count", 32'(count), 32'd0);
    chk("empty_pop_empty", 32'(empty), 32'd1);

    // Reset mid-stream with entries queued and one in the decode stage.
    key_code = 32'h21; step();
    key_code = 32'h22; step();
    key_code = 32'h23; step();
    key_code = 32'h24; step();
    key_code = 32'h0;  step();
    chk("midrst_pre_count", 32'(count), 32'd3);
    clrn = 1'b0;
    #1;
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_rd_data", rd_data, 32'h0);
    step();
    clrn = 1'b1;
    repeat (4) step();
    chk("midrst_after_count", 32'(count), 32'd0);

    // Random traffic against the model: slow reads first, then fast reads.
    for (int it = 0; it < 4000; it++) begin
      if ($urandom_range(0, 3) != 0) key_code = rand_code();
      en      = ($urandom_range(0, 9) != 0);
      rd_en   = (it < 1500) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 6);
      clr_ovf = ($urandom_range(0, 15) == 0);
      if (it == 2000) begin
        clrn = 1'b0; step(); clrn = 1'b1;
      end else begin
        step();
      end
    end
    rd_en = 1'b0; clr_ovf = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
